// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with logic, add/sub, compares, shifts and optional multiply.
// Latency: single-cycle ops register at the accept edge; MUL takes WIDTH further cycles.
// Backpressure: in_ready drops while a MUL iterates or while a result waits on out_ready.
// Optional multiplier is compiled in when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1101;
`endif

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OUT  = 2'd2
    } state_t;
`endif

    state_t state;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_err;

`ifdef ALU_PIPE_MUL_EN
    logic               is_mul;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [SHW-1:0]     cnt;
    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] acc_nxt;

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (acc[0]) is set, then shift the whole thing right.
    assign psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_nxt = {psum, acc[WIDTH-1:1]};
`endif

    // Ready when idle, or when the held result is being taken this cycle.
    assign in_ready = (state == S_IDLE) || ((state == S_OUT) && out_ready);
    assign accept   = in_valid && in_ready;

    assign shamt   = src2[SHW-1:0];
    assign sum_add = {1'b0, src1} + {1'b0, src2};
    // Subtract as src1 + ~src2 + 1 so the carry reads as "no borrow".
    assign sum_sub = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle datapath: result and flags for the operation on the inputs.
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
`ifdef ALU_PIPE_MUL_EN
        is_mul   = 1'b0;
`endif
        case (ALU_control)
            OP_AND:  alu_res = src1 & src2;
            OP_OR:   alu_res = src1 | src2;
            OP_NOR:  alu_res = ~(src1 | src2);
            OP_ADD: begin
                alu_res  = sum_add[WIDTH-1:0];
                alu_cout = sum_add[WIDTH];
                alu_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) &&
                           (sum_add[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res  = sum_sub[WIDTH-1:0];
                alu_cout = sum_sub[WIDTH];
                alu_ovf  = (src1[WIDTH-1] != src2[WIDTH-1]) &&
                           (sum_sub[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
            OP_SLL:  alu_res = src1 << shamt;
            OP_SRL:  alu_res = src1 >> shamt;
            OP_SRA:  alu_res = $signed(src1) >>> shamt;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  is_mul = 1'b1;
`endif
            default: alu_err = 1'b1;
        endcase
    end

    // Control FSM plus registered result/flags; flags always move with result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
`endif
        end else if (accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (is_mul) begin
                mcand     <= src1;
                acc       <= {{WIDTH{1'b0}}, src2};
                cnt       <= '0;
                state     <= S_MUL;
                out_valid <= 1'b0;
            end else
`endif
            begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                cout      <= alu_cout;
                overflow  <= alu_ovf;
                err       <= alu_err;
                state     <= S_OUT;
                out_valid <= 1'b1;
            end
        end else begin
            case (state)
`ifdef ALU_PIPE_MUL_EN
                S_MUL: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH-1)) begin
                        result    <= acc_nxt[WIDTH-1:0];
                        zero      <= (acc_nxt[WIDTH-1:0] == '0);
                        cout      <= 1'b0;
                        overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
                        err       <= 1'b0;
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                    end
                end
`endif
                S_OUT: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
